matrix_frame_writer: RTL and testbench



---
 rtl/matrix_frame_writer_pkg.sv | 22 ++
 rtl/matrix_frame_writer_if.sv | 24 ++
 rtl/matrix_frame_writer_wb_single_write.sv | 70 +++++++
 rtl/matrix_frame_writer.sv | 141 ++++++++++++++
 tb/tb_matrix_frame_writer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_frame_writer_pkg.sv
// rtl/matrix_frame_writer_pkg.sv - shared constants, types and row packing for matrix_frame_writer
package matrix_pkg;
   localparam int MATRIX_ROWS = 8;
   localparam int MATRIX_COLS = 8;
   localparam int ROW_W       = 3;
   localparam int WB_DW       = 32;
   localparam int WB_SELW     = 4;

   typedef logic [2:0] rgb_t;

   typedef enum logic [2:0] {COLLECT, WR_REQ, WR_WAIT, CLR_REQ, CLR_WAIT} fw_state_t;

   // Column c owns nibble c: byte lane c/2, low nibble for even c, high for odd; nibble bit 3 stays 0.
   function automatic logic [WB_DW-1:0] pack_pixel(input logic [WB_DW-1:0] row_word,
                                                  input logic [ROW_W-1:0] col,
                                                  input rgb_t             rgb);
      logic [WB_DW-1:0] w;
      w = row_word;
      w[{col, 2'b00} +: 4] = {1'b0, rgb};
      return w;
   endfunction
endpackage

// File: rtl/matrix_frame_writer_if.sv
// rtl/matrix_frame_writer_if.sv - Wishbone master/slave bundle between frame writer and matrix slave
interface matrix_frame_writer_if;
   import matrix_pkg::*;

   logic               o_wb_cyc;
   logic               o_wb_stb;
   logic               o_wb_we;
   logic [ROW_W-1:0]   o_wb_addr;
   logic [WB_SELW-1:0] o_wb_sel;
   logic [WB_DW-1:0]   o_wb_wdata;
   logic               i_wb_ack;
   logic               i_wb_stall;
   logic [WB_DW-1:0]   i_wb_rdata;

   modport master (
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_sel, o_wb_wdata,
      input  i_wb_ack, i_wb_stall, i_wb_rdata
   );

   modport slave (
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_sel, o_wb_wdata,
      output i_wb_ack, i_wb_stall, i_wb_rdata
   );
endinterface

// File: rtl/matrix_frame_writer_wb_single_write.sv
// rtl/matrix_frame_writer_wb_single_write.sv - one-beat Wishbone write engine with stall/ack and ack timeout
module wb_single_write
   import matrix_pkg::*;
#(
   parameter int ACK_TIMEOUT = 255,
   parameter int TO_W        = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start_i,
   input  logic [ROW_W-1:0]     addr_i,
   input  logic [WB_DW-1:0]     data_i,
   output logic                 done_o,
   output logic                 timeout_o,
   matrix_frame_writer_if.master wb
);
   logic             cyc_q, cyc_d;
   logic             stb_q, stb_d;
   logic [ROW_W-1:0] addr_q, addr_d;
   logic [WB_DW-1:0] data_q, data_d;
   logic [TO_W-1:0]  cnt_q, cnt_d;

   // An ack counts once the request is taken, which includes the cycle stall drops.
   assign done_o    = cyc_q && wb.i_wb_ack && !(stb_q && wb.i_wb_stall);
   assign timeout_o = cyc_q && !done_o && (cnt_q == TO_W'(ACK_TIMEOUT - 1));

   always_comb begin
      cyc_d  = cyc_q;
      stb_d  = stb_q;
      addr_d = addr_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      if (start_i) begin
         cyc_d  = 1'b1;
         stb_d  = 1'b1;
         addr_d = addr_i;
         data_d = data_i;
         cnt_d  = '0;
      end else if (done_o || timeout_o) begin
         cyc_d = 1'b0;
         stb_d = 1'b0;
      end else if (cyc_q) begin
         cnt_d = cnt_q + TO_W'(1);
         if (!wb.i_wb_stall) stb_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q  <= 1'b0;
         stb_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         cyc_q  <= cyc_d;
         stb_q  <= stb_d;
         addr_q <= addr_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign wb.o_wb_cyc   = cyc_q;
   assign wb.o_wb_stb   = stb_q;
   assign wb.o_wb_we    = cyc_q;
   assign wb.o_wb_sel   = {WB_SELW{cyc_q}};
   assign wb.o_wb_addr  = addr_q;
   assign wb.o_wb_wdata = data_q;
endmodule

// File: rtl/matrix_frame_writer.sv
// rtl/matrix_frame_writer.sv - packs an RGB pixel stream into row words and writes them to the matrix slave
module matrix_frame_writer
   import matrix_pkg::*;
#(
   parameter int ACK_TIMEOUT = 255,
   parameter int TO_W        = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_pix_valid,
   input  rgb_t                 i_pix_rgb,
   input  logic                 i_pix_sof,
   output logic                 o_pix_ready,
   input  logic                 i_clear,
   output logic                 o_frame_done,
   output logic                 o_err,
   output logic                 o_busy,
   matrix_frame_writer_if.master wb
);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MATRIX_ROWS - 1);
   localparam logic [ROW_W-1:0] LAST_COL = ROW_W'(MATRIX_COLS - 1);

   fw_state_t        state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d, col_q, col_d;
   logic [WB_DW-1:0] buf_q, buf_d, wr_data;
   logic             pend_q, pend_d, err_q, err_d, fdone_q, fdone_d, live_q;
   logic             start, eng_done, eng_timeout, finish, accept, unused_rdata;

   assign unused_rdata = ^wb.i_wb_rdata;
   assign finish       = eng_done || eng_timeout;
   // live_q keeps ready low until the first clock after reset release.
   assign o_pix_ready  = live_q && (state_q == COLLECT) && !i_clear;
   assign accept       = o_pix_ready && i_pix_valid;
   assign o_busy       = wb.o_wb_cyc || (state_q != COLLECT);
   assign o_err        = err_q;
   assign o_frame_done = fdone_q;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      buf_d   = buf_q;
      pend_d  = pend_q;
      err_d   = err_q | eng_timeout;
      fdone_d = 1'b0;
      start   = 1'b0;
      wr_data = '0;
      unique case (state_q)
         COLLECT: begin
            if (i_clear) begin
               row_d   = '0;
               col_d   = '0;
               buf_d   = '0;
               start   = 1'b1;
               state_d = CLR_REQ;
            end else if (accept) begin
               if (i_pix_sof) begin
                  row_d = '0;
                  col_d = ROW_W'(1);
                  buf_d = pack_pixel('0, '0, i_pix_rgb);
               end else begin
                  buf_d = pack_pixel(buf_q, col_q, i_pix_rgb);
                  if (col_q == LAST_COL) begin
                     col_d   = '0;
                     start   = 1'b1;
                     wr_data = buf_d;
                     state_d = WR_REQ;
                  end else begin
                     col_d = col_q + ROW_W'(1);
                  end
               end
            end
         end
         WR_REQ, WR_WAIT: begin
            if (i_clear) pend_d = 1'b1;
            if (finish) begin
               fdone_d = eng_done && (row_q == LAST_ROW);
               if (pend_q || i_clear) begin
                  pend_d  = 1'b0;
                  row_d   = '0;
                  start   = 1'b1;
                  state_d = CLR_REQ;
               end else begin
                  row_d   = row_q + ROW_W'(1);
                  state_d = COLLECT;
               end
            end else if (state_q == WR_REQ && !wb.i_wb_stall) begin
               state_d = WR_WAIT;
            end
         end
         CLR_REQ, CLR_WAIT: begin
            if (finish) begin
               if (row_q == LAST_ROW) begin
                  row_d   = '0;
                  state_d = COLLECT;
               end else begin
                  row_d   = row_q + ROW_W'(1);
                  start   = 1'b1;
                  state_d = CLR_REQ;
               end
            end else if (state_q == CLR_REQ && !wb.i_wb_stall) begin
               state_d = CLR_WAIT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= COLLECT;
         row_q   <= '0;
         col_q   <= '0;
         buf_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         fdone_q <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         buf_q   <= buf_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         fdone_q <= fdone_d;
         live_q  <= 1'b1;
      end
   end

   wb_single_write #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)) u_wr (
      .clk       (clk),
      .reset_n   (reset_n),
      .start_i   (start),
      .addr_i    (row_d),
      .data_i    (wr_data),
      .done_o    (eng_done),
      .timeout_o (eng_timeout),
      .wb        (wb)
   );
endmodule

// File: tb/tb_matrix_frame_writer.sv
// tb/tb_matrix_frame_writer.sv - table plus scoreboard bench for matrix_frame_writer
module tb_matrix_frame_writer;
   typedef struct {
      logic            sof;
      logic [7:0][2:0] pix;
      int              stall;
      logic [2:0]      addr;
      logic [31:0]     data;
   } vec_t;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk, reset_n, i_pix_valid, i_pix_sof, o_pix_ready, i_clear, o_frame_done, o_err, o_busy;
   logic [2:0] i_pix_rgb;

   matrix_frame_writer_if wb();

   matrix_frame_writer #(.ACK_TIMEOUT(16), .TO_W(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_pix_valid  (i_pix_valid),
      .i_pix_rgb    (i_pix_rgb),
      .i_pix_sof    (i_pix_sof),
      .o_pix_ready  (o_pix_ready),
      .i_clear      (i_clear),
      .o_frame_done (o_frame_done),
      .o_err        (o_err),
      .o_busy       (o_busy),
      .wb           (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  n_vec = 0;
   int  n_err = 0;
   int  stall_cfg = 0;
   int  ack_delay = 1;
   bit  ack_en = 1'b1;
   int  fd_cnt = 0;
   wr_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Slave model: stalls each new request stall_cfg cycles, acks ack_delay cycles after acceptance.
   initial begin : slave
      int         stall_left;
      int         ack_wait;
      logic       stb_prev;
      logic [2:0] h_addr;
      logic [31:0] h_data;
      wr_t        e;
      stall_left = 0;
      ack_wait   = 0;
      stb_prev   = 1'b0;
      h_addr     = '0;
      h_data     = '0;
      wb.i_wb_ack   = 1'b0;
      wb.i_wb_stall = 1'b0;
      wb.i_wb_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (o_frame_done) fd_cnt++;
         wb.i_wb_ack = 1'b0;
         if (ack_wait > 0) begin
            ack_wait--;
            if (ack_wait == 0 && ack_en) wb.i_wb_ack = 1'b1;
         end
         if (wb.o_wb_stb && !stb_prev) begin
            stall_left = stall_cfg;
            h_addr     = wb.o_wb_addr;
            h_data     = wb.o_wb_wdata;
         end else if (wb.o_wb_stb) begin
            check("stall_addr_stable", wb.o_wb_addr, h_addr);
            check("stall_data_stable", wb.o_wb_wdata, h_data);
            check("stall_ready_low", o_pix_ready, 0);
         end
         if (wb.o_wb_stb) begin
            if (stall_left > 0) begin
               wb.i_wb_stall = 1'b1;
               stall_left--;
            end else begin
               wb.i_wb_stall = 1'b0;
               ack_wait = ack_delay;
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_write: addr %h data %h, none expected", wb.o_wb_addr, wb.o_wb_wdata);
               end else begin
                  e = sb.pop_front();
                  check("wr_addr", wb.o_wb_addr, e.addr);
                  check("wr_data", wb.o_wb_wdata, e.data);
                  check("wr_sel", wb.o_wb_sel, 4'hF);
                  check("wr_we", wb.o_wb_we, 1);
               end
            end
         end else begin
            wb.i_wb_stall = 1'b0;
         end
         stb_prev = wb.o_wb_stb;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [2:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic send_pix(input logic [2:0] rgb, input logic sof);
      int   n;
      logic acc;
      n = 0;
      i_pix_valid = 1'b1;
      i_pix_rgb   = rgb;
      i_pix_sof   = sof;
      do begin
         @(negedge clk);
         acc = o_pix_ready;
         tick();
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL pix_accept_timeout: ready never high in %0d cycles", n);
      end
      i_pix_valid = 1'b0;
      i_pix_sof   = 1'b0;
   endtask

   task automatic send_row(input logic [7:0][2:0] pix, input logic sof_first);
      for (int c = 0; c < 8; c++) send_pix(pix[c], (c == 0) && sof_first);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (o_busy && n < 400) begin
         tick();
         n++;
      end
      if (o_busy) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout: busy still high after %0d cycles", n);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      vec_t tab[12];
      int   n;
      for (int i = 0; i < 8; i++) begin
         tab[i].sof   = (i == 0);
         tab[i].pix   = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
         tab[i].stall = 0;
         tab[i].addr  = 3'(i);
         tab[i].data  = 32'h7654_3210;
      end
      tab[8]  = '{1'b0, {8{3'd7}}, 0, 3'd0, 32'h7777_7777};
      tab[9]  = '{1'b0, {{7{3'd0}}, 3'd5}, 0, 3'd1, 32'h0000_0005};
      tab[10] = '{1'b0, {3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0}, 5, 3'd2, 32'h1010_1010};
      tab[11] = '{1'b0, {3'd4, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2, 3'd2, 3'd2}, 0, 3'd3, 32'h4444_2222};

      reset_n = 1'b0;
      i_pix_valid = 1'b0;
      i_pix_rgb   = '0;
      i_pix_sof   = 1'b0;
      i_clear     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", o_pix_ready, 0);
      check("rst_cyc", wb.o_wb_cyc, 0);
      check("rst_stb", wb.o_wb_stb, 0);
      check("rst_sel", wb.o_wb_sel, 0);
      check("rst_wdata", wb.o_wb_wdata, 0);
      check("rst_err", o_err, 0);
      check("rst_busy", o_busy, 0);
      check("rst_frame_done", o_frame_done, 0);
      reset_n = 1'b1;
      tick();
      check("ready_after_reset", o_pix_ready, 1);

      for (int i = 0; i < 12; i++) begin
         stall_cfg = tab[i].stall;
         push(tab[i].addr, tab[i].data);
         send_row(tab[i].pix, tab[i].sof);
         wait_idle();
         check("row_drained", sb.size(), 0);
         if (i == 6 || i == 7) check("frame_done_cnt", fd_cnt, (i == 7) ? 1 : 0);
      end
      stall_cfg = 0;

      // SOF mid-row restarts at (0,0)
      push(3'd0, 32'h0000_0005);
      repeat (3) send_pix(3'd1, 1'b0);
      send_pix(3'b101, 1'b1);
      repeat (7) send_pix(3'd0, 1'b0);
      wait_idle();
      check("sof_drained", sb.size(), 0);

      // Clear arriving in WR_WAIT of row 4
      for (int r = 1; r < 4; r++) begin
         push(3'(r), 32'h2222_2222);
         send_row({8{3'd2}}, 1'b0);
         wait_idle();
      end
      push(3'd4, 32'h6666_6666);
      for (int r = 0; r < 8; r++) push(3'(r), 32'h0);
      ack_delay = 4;
      send_row({8{3'd6}}, 1'b0);
      tick();
      check("wait_cyc", wb.o_wb_cyc, 1);
      check("wait_stb", wb.o_wb_stb, 0);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      ack_delay = 1;
      wait_idle();
      check("clear_drained", sb.size(), 0);
      check("clear_no_frame_done", fd_cnt, 1);
      push(3'd0, 32'h1111_1111);
      send_row({8{3'd1}}, 1'b0);
      wait_idle();
      check("post_clear_drained", sb.size(), 0);

      // Clear and pixel together in COLLECT: clear wins
      for (int r = 0; r < 8; r++) push(3'(r), 32'h0);
      i_pix_valid = 1'b1;
      i_pix_rgb   = 3'd7;
      i_clear     = 1'b1;
      @(negedge clk);
      check("ready_on_clear", o_pix_ready, 0);
      tick();
      i_clear     = 1'b0;
      i_pix_valid = 1'b0;
      check("busy_in_clear", o_busy, 1);
      wait_idle();
      check("clear2_drained", sb.size(), 0);

      // Ack timeout
      push(3'd0, 32'h3333_3333);
      ack_en = 1'b0;
      send_row({8{3'd3}}, 1'b0);
      n = 0;
      while (wb.o_wb_cyc && n < 100) begin
         n++;
         tick();
      end
      check("timeout_cyc_cycles", n, 16);
      check("timeout_err_set", o_err, 1);
      ack_en = 1'b1;
      push(3'd1, 32'h4444_4444);
      send_row({8{3'd4}}, 1'b0);
      wait_idle();
      check("timeout_next_drained", sb.size(), 0);
      check("err_sticky", o_err, 1);

      // Reset while stb held by stall
      stall_cfg = 1000;
      send_row({8{3'd5}}, 1'b0);
      repeat (3) tick();
      check("hold_stb", wb.o_wb_stb, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_cyc", wb.o_wb_cyc, 0);
      check("async_stb", wb.o_wb_stb, 0);
      check("async_ready", o_pix_ready, 0);
      check("async_err", o_err, 0);
      stall_cfg = 0;
      wb.i_wb_stall = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("ready_after_rerst", o_pix_ready, 1);
      push(3'd0, 32'h5555_5555);
      send_row({8{3'd5}}, 1'b0);
      wait_idle();
      check("final_drained", sb.size(), 0);
      check("final_frame_done_cnt", fd_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
